// File: rtl/rob_request_buffer_pkg.sv
// Shared field widths, LoS encodings and the packed entry layout for the request reorder buffer.
package rob_request_buffer_pkg;

    localparam int unsigned ROB_ITEM_W = 36;
    localparam int unsigned DADDR_W    = 11;
    localparam int unsigned SIZE_W     = 2;
    localparam int unsigned LOS_W      = 2;
    localparam int unsigned BANK_W     = 2;
    localparam int unsigned ROW_W      = 11;
    localparam int unsigned COL_W      = 8;
    localparam int unsigned COUNT_W    = 5;

    localparam logic [LOS_W-1:0] LOS_WR = 2'b01;
    localparam logic [LOS_W-1:0] LOS_RD = 2'b10;

    // Field order matches the read-port layout {daddr,size,los,bank,row,col}.
    typedef struct packed {
        logic [DADDR_W-1:0] daddr;
        logic [SIZE_W-1:0]  size;
        logic [LOS_W-1:0]   los;
        logic [BANK_W-1:0]  bank;
        logic [ROW_W-1:0]   row;
        logic [COL_W-1:0]   col;
    } rob_item_t;

    function automatic logic los_legal(input logic [LOS_W-1:0] los);
        return (los == LOS_WR) || (los == LOS_RD);
    endfunction

endpackage

// File: rtl/rob_request_buffer_select.sv
// Combinational entry picker: hazard-aware row-hit selection with a forced-oldest override.
module rob_select
    import rob_request_buffer_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]  valid,
    input  logic [BANK_W-1:0] bank [DEPTH],
    input  logic [ROW_W-1:0]  row  [DEPTH],
    input  logic [COL_W-1:0]  col  [DEPTH],
    input  logic [LOS_W-1:0]  los  [DEPTH],
    input  logic              trk_valid,
    input  logic [BANK_W-1:0] trk_bank,
    input  logic [ROW_W-1:0]  trk_row,
    input  logic              force_oldest,
    output logic [IDX_W-1:0]  sel_idx,
    output logic              hit
);

    logic [DEPTH-1:0] eligible;

    // An entry is blocked by any older valid entry to the same address when either side is a write.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < DEPTH; i++) begin
            eligible[i] = valid[i];
            for (int j = 0; j < DEPTH; j++) begin
                if ((j < i) && valid[j] &&
                    (bank[j] == bank[i]) && (row[j] == row[i]) && (col[j] == col[i]) &&
                    ((los[i] == LOS_WR) || (los[j] == LOS_WR))) begin
                    eligible[i] = 1'b0;
                end
            end
        end
    end

    // Descending scan so the lowest matching index wins.
    always_comb begin
        sel_idx = '0;
        hit     = 1'b0;
        if (!force_oldest && trk_valid) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (eligible[i] && (bank[i] == trk_bank) && (row[i] == trk_row)) begin
                    sel_idx = IDX_W'(i);
                    hit     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rob_request_buffer.sv
// Age-ordered request reorder buffer with show-ahead read port, row-hit preference and a starvation bound.
module rob_request_buffer
    import rob_request_buffer_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned MAX_BYPASS = 4
) (
    input  logic                  sclk,
    input  logic                  sreset,
    input  logic                  iReq_Valid,
    output logic                  oReq_Ready,
    input  logic [DADDR_W-1:0]    iReq_DAddr,
    input  logic [SIZE_W-1:0]     iReq_Size,
    input  logic [LOS_W-1:0]      iReq_LoS,
    input  logic [BANK_W-1:0]     iReq_Bank,
    input  logic [ROW_W-1:0]      iReq_Row,
    input  logic [COL_W-1:0]      iReq_Col,
    output logic                  oReq_Err,
    output logic                  oROB_Empty,
    output logic                  oROB_Full,
    input  logic                  iROB_Rd,
    output logic [ROB_ITEM_W-1:0] oROB_RdData,
    output logic [COUNT_W-1:0]    oROB_Count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned BYP_W = $clog2(MAX_BYPASS + 1);

    rob_item_t             entries     [DEPTH];
    rob_item_t             nxt_entries [DEPTH];
    logic [COUNT_W-1:0]    count;
    logic                  err_q;
    logic                  trk_valid;
    logic [BANK_W-1:0]     trk_bank;
    logic [ROW_W-1:0]      trk_row;
    logic [BYP_W-1:0]      bypass_cnt;

    logic [DEPTH-1:0]      valid_vec;
    logic [BANK_W-1:0]     bank_arr [DEPTH];
    logic [ROW_W-1:0]      row_arr  [DEPTH];
    logic [COL_W-1:0]      col_arr  [DEPTH];
    logic [LOS_W-1:0]      los_arr  [DEPTH];
    logic [IDX_W-1:0]      sel_idx;
    logic                  sel_hit;

    logic                  empty;
    logic                  full;
    logic                  req_fire;
    logic                  push;
    logic                  illegal;
    logic                  pop;
    logic                  force_oldest;
    logic [COUNT_W-1:0]    wr_pos;
    rob_item_t             new_item;

    assign empty        = (count == '0);
    assign full         = (count == COUNT_W'(DEPTH));
    assign req_fire     = iReq_Valid && !full;
    assign push         = req_fire && los_legal(iReq_LoS);
    assign illegal      = req_fire && !los_legal(iReq_LoS);
    assign pop          = iROB_Rd && !empty;
    assign force_oldest = (bypass_cnt == BYP_W'(MAX_BYPASS));
    assign wr_pos       = count - COUNT_W'(pop);

    assign oReq_Ready  = !full;
    assign oROB_Empty  = empty;
    assign oROB_Full   = full;
    assign oROB_Count  = count;
    assign oReq_Err    = err_q;
    assign oROB_RdData = empty ? '0 : entries[sel_idx];

    // Read entries never carry a write-data index.
    always_comb begin
        new_item.daddr = (iReq_LoS == LOS_RD) ? '0 : iReq_DAddr;
        new_item.size  = iReq_Size;
        new_item.los   = iReq_LoS;
        new_item.bank  = iReq_Bank;
        new_item.row   = iReq_Row;
        new_item.col   = iReq_Col;
    end

    always_comb begin
        valid_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i] = (COUNT_W'(i) < count);
            bank_arr[i]  = entries[i].bank;
            row_arr[i]   = entries[i].row;
            col_arr[i]   = entries[i].col;
            los_arr[i]   = entries[i].los;
        end
    end

    rob_select #(
        .DEPTH (DEPTH)
    ) u_select (
        .valid        (valid_vec),
        .bank         (bank_arr),
        .row          (row_arr),
        .col          (col_arr),
        .los          (los_arr),
        .trk_valid    (trk_valid),
        .trk_bank     (trk_bank),
        .trk_row      (trk_row),
        .force_oldest (force_oldest),
        .sel_idx      (sel_idx),
        .hit          (sel_hit)
    );

    // Compact out the popped slot first, then append at the post-pop tail.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            nxt_entries[i] = entries[i];
        end
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (IDX_W'(i) >= sel_idx) begin
                    nxt_entries[i] = entries[i + 1];
                end
            end
            nxt_entries[DEPTH-1] = '0;
        end
        if (push) begin
            nxt_entries[wr_pos[IDX_W-1:0]] = new_item;
        end
    end

    always_ff @(posedge sclk) begin
        if (sreset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            count      <= '0;
            err_q      <= 1'b0;
            trk_valid  <= 1'b0;
            trk_bank   <= '0;
            trk_row    <= '0;
            bypass_cnt <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= nxt_entries[i];
            end
            count <= count + COUNT_W'(push) - COUNT_W'(pop);
            err_q <= illegal;
            if (pop) begin
                trk_valid <= 1'b1;
                trk_bank  <= entries[sel_idx].bank;
                trk_row   <= entries[sel_idx].row;
                // Only a row-hit can move the pick away from index 0, so that is what counts as a bypass.
                if (sel_hit && (sel_idx != '0)) begin
                    if (!force_oldest) begin
                        bypass_cnt <= bypass_cnt + BYP_W'(1);
                    end
                end else begin
                    bypass_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_request_buffer.sv
// Directed bench for rob_request_buffer: ordering, hazards, starvation, full/empty edges, errors and reset.
module tb_rob_request_buffer;
    import rob_request_buffer_pkg::*;

    logic                  sclk = 1'b0;
    logic                  sreset;
    logic                  iReq_Valid;
    logic                  oReq_Ready;
    logic [DADDR_W-1:0]    iReq_DAddr;
    logic [SIZE_W-1:0]     iReq_Size;
    logic [LOS_W-1:0]      iReq_LoS;
    logic [BANK_W-1:0]     iReq_Bank;
    logic [ROW_W-1:0]      iReq_Row;
    logic [COL_W-1:0]      iReq_Col;
    logic                  oReq_Err;
    logic                  oROB_Empty;
    logic                  oROB_Full;
    logic                  iROB_Rd;
    logic [ROB_ITEM_W-1:0] oROB_RdData;
    logic [COUNT_W-1:0]    oROB_Count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 sclk = ~sclk;

    rob_request_buffer #(
        .DEPTH      (8),
        .MAX_BYPASS (4)
    ) dut (
        .sclk        (sclk),
        .sreset      (sreset),
        .iReq_Valid  (iReq_Valid),
        .oReq_Ready  (oReq_Ready),
        .iReq_DAddr  (iReq_DAddr),
        .iReq_Size   (iReq_Size),
        .iReq_LoS    (iReq_LoS),
        .iReq_Bank   (iReq_Bank),
        .iReq_Row    (iReq_Row),
        .iReq_Col    (iReq_Col),
        .oReq_Err    (oReq_Err),
        .oROB_Empty  (oROB_Empty),
        .oROB_Full   (oROB_Full),
        .iROB_Rd     (iROB_Rd),
        .oROB_RdData (oROB_RdData),
        .oROB_Count  (oROB_Count)
    );

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] item(input logic [10:0] d, input logic [1:0] s, input logic [1:0] l,
                                         input logic [1:0] b, input logic [10:0] r, input logic [7:0] c);
        return {d, s, l, b, r, c};
    endfunction

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic do_reset();
        sreset = 1'b1;
        step();
        sreset = 1'b0;
    endtask

    task automatic set_req(input logic [1:0] l, input logic [1:0] b, input logic [10:0] r,
                           input logic [7:0] c, input logic [10:0] d);
        iReq_LoS   = l;
        iReq_Bank  = b;
        iReq_Row   = r;
        iReq_Col   = c;
        iReq_DAddr = d;
        iReq_Size  = 2'd1;
    endtask

    task automatic push(input logic [1:0] l, input logic [1:0] b, input logic [10:0] r,
                        input logic [7:0] c, input logic [10:0] d);
        set_req(l, b, r, c, d);
        iReq_Valid = 1'b1;
        step();
        iReq_Valid = 1'b0;
    endtask

    task automatic pop();
        iROB_Rd = 1'b1;
        step();
        iROB_Rd = 1'b0;
    endtask

    initial begin
        sreset     = 1'b1;
        iReq_Valid = 1'b0;
        iROB_Rd    = 1'b0;
        set_req(2'b00, 2'd0, 11'd0, 8'd0, 11'd0);
        step();
        step();
        sreset = 1'b0;

        // Reset state
        check("rst_empty", 36'(oROB_Empty), 36'd1);
        check("rst_full",  36'(oROB_Full),  36'd0);
        check("rst_count", 36'(oROB_Count), 36'd0);
        check("rst_err",   36'(oReq_Err),   36'd0);
        check("rst_rddata", oROB_RdData,    36'd0);
        check("rst_ready", 36'(oReq_Ready), 36'd1);

        // 1: row-hit reordering
        do_reset();
        push(LOS_RD, 2'd0, 11'd5, 8'd0, 11'd0);
        push(LOS_RD, 2'd1, 11'd9, 8'd0, 11'd0);
        push(LOS_RD, 2'd0, 11'd5, 8'd4, 11'd0);
        check("t1_count", 36'(oROB_Count), 36'd3);
        check("t1_pop1", oROB_RdData, item(11'd0, 2'd1, LOS_RD, 2'd0, 11'd5, 8'd0));
        pop();
        check("t1_pop2", oROB_RdData, item(11'd0, 2'd1, LOS_RD, 2'd0, 11'd5, 8'd4));
        pop();
        check("t1_byp_mid", 36'(dut.bypass_cnt), 36'd1);
        check("t1_pop3", oROB_RdData, item(11'd0, 2'd1, LOS_RD, 2'd1, 11'd9, 8'd0));
        pop();
        check("t1_empty", 36'(oROB_Empty), 36'd1);
        check("t1_byp_end", 36'(dut.bypass_cnt), 36'd0);

        // 2: write before same-address read, read daddr forced to 0
        do_reset();
        push(LOS_RD, 2'd2, 11'd3, 8'd0, 11'd0);
        pop();
        push(LOS_RD, 2'd1, 11'd1, 8'd1, 11'd0);
        push(LOS_WR, 2'd2, 11'd3, 8'd8, 11'd7);
        push(LOS_RD, 2'd2, 11'd3, 8'd8, 11'd99);
        check("t2_write_first", oROB_RdData, item(11'd7, 2'd1, LOS_WR, 2'd2, 11'd3, 8'd8));
        pop();
        check("t2_read_next", oROB_RdData, item(11'd0, 2'd1, LOS_RD, 2'd2, 11'd3, 8'd8));
        pop();
        check("t2_unrelated", oROB_RdData, item(11'd0, 2'd1, LOS_RD, 2'd1, 11'd1, 8'd1));
        pop();

        // 3: starvation bound
        do_reset();
        push(LOS_RD, 2'd0, 11'd0, 8'd0, 11'd0);
        pop();
        push(LOS_RD, 2'd3, 11'd1, 8'd0, 11'd0);
        for (int k = 1; k <= 6; k++) push(LOS_RD, 2'd0, 11'd0, 8'(k), 11'd0);
        check("t3_count", 36'(oROB_Count), 36'd7);
        for (int p = 1; p <= 4; p++) begin
            check($sformatf("t3_hit%0d", p), oROB_RdData, item(11'd0, 2'd1, LOS_RD, 2'd0, 11'd0, 8'(p)));
            pop();
        end
        check("t3_byp_sat", 36'(dut.bypass_cnt), 36'd4);
        check("t3_forced", oROB_RdData, item(11'd0, 2'd1, LOS_RD, 2'd3, 11'd1, 8'd0));
        pop();
        check("t3_byp_clr", 36'(dut.bypass_cnt), 36'd0);
        check("t3_after", oROB_RdData, item(11'd0, 2'd1, LOS_RD, 2'd0, 11'd0, 8'd5));

        // 4: full, held request accepted one cycle after the pop
        do_reset();
        for (int i = 0; i < 8; i++) push(LOS_RD, 2'(i % 4), 11'(i), 8'd0, 11'd0);
        check("t4_full",  36'(oROB_Full),  36'd1);
        check("t4_ready", 36'(oReq_Ready), 36'd0);
        check("t4_count", 36'(oROB_Count), 36'd8);
        set_req(LOS_RD, 2'd1, 11'd20, 8'd3, 11'd0);
        iReq_Valid = 1'b1;
        iROB_Rd    = 1'b1;
        step();
        iROB_Rd = 1'b0;
        check("t4_no_bypass", 36'(oROB_Count), 36'd7);
        check("t4_ready_again", 36'(oReq_Ready), 36'd1);
        step();
        iReq_Valid = 1'b0;
        check("t4_refill", 36'(oROB_Count), 36'd8);
        check("t4_full2",  36'(oROB_Full),  36'd1);

        // 5: simultaneous push/pop, then read while empty
        do_reset();
        push(LOS_RD, 2'd0, 11'd1, 8'd0, 11'd0);
        push(LOS_RD, 2'd1, 11'd1, 8'd0, 11'd0);
        push(LOS_RD, 2'd2, 11'd1, 8'd0, 11'd0);
        set_req(LOS_RD, 2'd3, 11'd1, 8'd0, 11'd0);
        iReq_Valid = 1'b1;
        iROB_Rd    = 1'b1;
        step();
        iReq_Valid = 1'b0;
        iROB_Rd    = 1'b0;
        check("t5_count", 36'(oROB_Count), 36'd3);
        check("t5_idx2", 36'(dut.entries[2]), item(11'd0, 2'd1, LOS_RD, 2'd3, 11'd1, 8'd0));
        check("t5_head", oROB_RdData, item(11'd0, 2'd1, LOS_RD, 2'd1, 11'd1, 8'd0));
        pop();
        pop();
        check("t5_last", oROB_RdData, item(11'd0, 2'd1, LOS_RD, 2'd3, 11'd1, 8'd0));
        pop();
        iROB_Rd = 1'b1;
        step();
        iROB_Rd = 1'b0;
        check("t5_empty_rd_count", 36'(oROB_Count), 36'd0);
        check("t5_empty_rd_empty", 36'(oROB_Empty), 36'd1);
        check("t5_empty_rd_data", oROB_RdData, 36'd0);
        check("t5_empty_rd_byp", 36'(dut.bypass_cnt), 36'd0);

        // 6: illegal LoS, then reset mid-traffic
        do_reset();
        push(LOS_RD, 2'd0, 11'd0, 8'd0, 11'd0);
        check("t6_err_idle", 36'(oReq_Err), 36'd0);
        push(2'b11, 2'd1, 11'd2, 8'd3, 11'd4);
        check("t6_err_pulse", 36'(oReq_Err), 36'd1);
        check("t6_err_count", 36'(oROB_Count), 36'd1);
        step();
        check("t6_err_clear", 36'(oReq_Err), 36'd0);
        push(LOS_WR, 2'd1, 11'd2, 8'd3, 11'd4);
        push(LOS_RD, 2'd2, 11'd2, 8'd3, 11'd0);
        check("t6_pre_rst", 36'(oROB_Count), 36'd3);
        sreset  = 1'b1;
        iROB_Rd = 1'b1;
        step();
        sreset  = 1'b0;
        iROB_Rd = 1'b0;
        check("t6_rst_empty", 36'(oROB_Empty), 36'd1);
        check("t6_rst_data", oROB_RdData, 36'd0);
        check("t6_rst_count", 36'(oROB_Count), 36'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
